// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the IF/ID pipeline register.
package fetch_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_WIDTH = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  flush_i,
    input  logic [INSTR_W-1:0]    instr_i,
    input  logic [ADDR_WIDTH-1:0] pc_plus4_i,
    output logic [INSTR_W-1:0]    instr_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    output logic                  valid_o
);

    logic [INSTR_W-1:0]    instr_q;
    logic [ADDR_WIDTH-1:0] pc_plus4_q;
    logic                  valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, redirect/flush and
// sticky misaligned-redirect fault, feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned         ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [INSTR_W-1:0]    inst_data,
    output logic [INSTR_W-1:0]    if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  fetch_fault
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  load;
    logic                  flush;

    // Wraps modulo 2^ADDR_WIDTH by construction.
    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Redirect beats stall; a misaligned redirect parks the stage in FAULT.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    flush = 1'b1;
                    if (is_word_aligned(branch_target[1:0])) begin
                        pc_d = branch_target;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else if (!stall) begin
                    pc_d = pc_plus4;
                    load = 1'b1;
                end
            end
            ST_FAULT: begin
                flush = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
                flush   = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .flush_i    (flush),
        .instr_i    (inst_data),
        .pc_plus4_i (pc_plus4),
        .instr_o    (if_id_instr),
        .pc_plus4_o (if_id_pc_plus4),
        .valid_o    (if_id_valid)
    );

    assign inst_addr   = pc_q;
    assign fetch_fault = (state_q == ST_FAULT);

endmodule
